// File: rtl/sdram_fifo_sched.sv
// Burst scheduler between the UART-side FIFOs and the SDRAM controller.
// Owns the write/read pointers and fill count of one circular SDRAM region.
module sdram_fifo_sched #(
  parameter logic [23:0] ADDR_MIN  = 24'd0,
  parameter logic [23:0] ADDR_MAX  = 24'd1023,
  parameter logic [9:0]  BURST_LEN = 10'd8,
  parameter int unsigned LVL_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_end,
  input  logic [LVL_W-1:0] wfifo_level,
  input  logic [LVL_W-1:0] rfifo_free,
  input  logic             rd_enable,
  input  logic             flush,
  output logic             wr_req,
  output logic [23:0]      wr_addr,
  output logic [9:0]       wr_burst_len,
  input  logic             sdram_wr_ack,
  output logic             rd_req,
  output logic [23:0]      rd_addr,
  output logic [9:0]       rd_burst_len,
  input  logic             rd_ack,
  output logic             wfifo_rd_en,
  output logic             rfifo_wr_en,
  output logic [24:0]      fill_words,
  output logic             busy,
  output logic             ack_err
);

  localparam logic [24:0] Cap    = 25'(ADDR_MAX) - 25'(ADDR_MIN) + 25'd1;
  localparam logic [24:0] BurstW = 25'(BURST_LEN);

  typedef enum logic [2:0] {StWaitInit, StIdle, StWrite, StRead, StDone} state_e;

  state_e      state_q;
  logic [9:0]  ack_cnt_q;
  logic        flush_pend_q;
  // Type of the most recent grant; also tells DONE which pointer to advance.
  logic        last_rd_q;

  logic [24:0] wlvl, rfree;
  logic        wr_ok, rd_ok, cnt_last;

  assign wlvl     = 25'(wfifo_level);
  assign rfree    = 25'(rfifo_free);
  assign wr_ok    = (wlvl >= BurstW) && ((Cap - fill_words) >= BurstW);
  assign rd_ok    = rd_enable && (fill_words >= BurstW) && (rfree >= BurstW);
  assign cnt_last = ({1'b0, ack_cnt_q} + 11'd1) == {1'b0, BURST_LEN};

  assign wr_burst_len = BURST_LEN;
  assign rd_burst_len = BURST_LEN;
  assign wfifo_rd_en  = sdram_wr_ack && (state_q == StWrite);
  assign rfifo_wr_en  = rd_ack && (state_q == StRead);
  assign busy         = (state_q == StWrite) || (state_q == StRead) || (state_q == StDone);

  function automatic logic [23:0] advance(input logic [23:0] ptr);
    logic [24:0] sum;
    sum = 25'(ptr) + BurstW;
    if (sum > 25'(ADDR_MAX)) return ADDR_MIN;
    return sum[23:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWaitInit;
      wr_req       <= 1'b0;
      rd_req       <= 1'b0;
      wr_addr      <= ADDR_MIN;
      rd_addr      <= ADDR_MIN;
      fill_words   <= '0;
      ack_err      <= 1'b0;
      ack_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      last_rd_q    <= 1'b1;
    end else begin
      if (flush && state_q != StIdle) flush_pend_q <= 1'b1;
      if ((sdram_wr_ack && state_q != StWrite) || (rd_ack && state_q != StRead)) begin
        ack_err <= 1'b1;
      end
      unique case (state_q)
        StWaitInit: begin
          if (init_end) state_q <= StIdle;
        end
        StIdle: begin
          if (flush || flush_pend_q) begin
            wr_addr      <= ADDR_MIN;
            rd_addr      <= ADDR_MIN;
            fill_words   <= '0;
            flush_pend_q <= 1'b0;
          end else if (wr_ok && (!rd_ok || last_rd_q)) begin
            state_q   <= StWrite;
            wr_req    <= 1'b1;
            last_rd_q <= 1'b0;
            ack_cnt_q <= '0;
          end else if (rd_ok) begin
            state_q   <= StRead;
            rd_req    <= 1'b1;
            last_rd_q <= 1'b1;
            ack_cnt_q <= '0;
          end
        end
        StWrite: begin
          if (sdram_wr_ack) begin
            wr_req    <= 1'b0;
            ack_cnt_q <= ack_cnt_q + 10'd1;
            if (cnt_last) state_q <= StDone;
          end
        end
        StRead: begin
          if (rd_ack) begin
            rd_req    <= 1'b0;
            ack_cnt_q <= ack_cnt_q + 10'd1;
            if (cnt_last) state_q <= StDone;
          end
        end
        StDone: begin
          if (last_rd_q) begin
            fill_words <= fill_words - BurstW;
            rd_addr    <= advance(rd_addr);
          end else begin
            fill_words <= fill_words + BurstW;
            wr_addr    <= advance(wr_addr);
          end
          state_q <= StIdle;
        end
        default: state_q <= StWaitInit;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_fifo_sched.sv
// Randomized bench for sdram_fifo_sched against a burst-level reference model.
module tb_sdram_fifo_sched;

  localparam int AMIN = 0;
  localparam int AMAX = 31;
  localparam int BL   = 8;
  localparam int CAP  = AMAX - AMIN + 1;

  logic        clk = 1'b0;
  logic        rst, init_end, rd_enable, flush, sdram_wr_ack, rd_ack;
  logic [9:0]  wfifo_level, rfifo_free;
  logic        wr_req, rd_req, wfifo_rd_en, rfifo_wr_en, busy, ack_err;
  logic [23:0] wr_addr, rd_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [24:0] fill_words;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_fill = 0, m_wptr = AMIN, m_rptr = AMIN;
  bit m_last_rd = 1'b1, m_pend = 1'b0, m_err = 1'b0;
  int m_wbursts = 0, m_rbursts = 0;
  int pops = 0, pushes = 0;

  sdram_fifo_sched #(
    .ADDR_MIN (24'(AMIN)),
    .ADDR_MAX (24'(AMAX)),
    .BURST_LEN(10'(BL)),
    .LVL_W    (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .init_end    (init_end),
    .wfifo_level (wfifo_level),
    .rfifo_free  (rfifo_free),
    .rd_enable   (rd_enable),
    .flush       (flush),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_burst_len(wr_burst_len),
    .sdram_wr_ack(sdram_wr_ack),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_burst_len(rd_burst_len),
    .rd_ack      (rd_ack),
    .wfifo_rd_en (wfifo_rd_en),
    .rfifo_wr_en (rfifo_wr_en),
    .fill_words  (fill_words),
    .busy        (busy),
    .ack_err     (ack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wfifo_rd_en) pops++;
    if (rfifo_wr_en) pushes++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int next_ptr(input int p);
    return (p - AMIN + BL) % CAP + AMIN;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_wr_req"}, 32'(wr_req), 0);
    check_eq({tag, "_rd_req"}, 32'(rd_req), 0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), AMIN);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr), AMIN);
    check_eq({tag, "_fill"}, 32'(fill_words), 0);
    check_eq({tag, "_ack_err"}, 32'(ack_err), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Feeds BL acks with random gaps, stray wrong-type acks and flush pulses, then DONE.
  task automatic run_burst(input bit is_wr);
    int gap;
    for (int k = 0; k < BL; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (is_wr) rd_ack = 1'b1;
          else sdram_wr_ack = 1'b1;
          m_err = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) begin
          flush  = 1'b1;
          m_pend = 1'b1;
        end
        #1;
        check_eq("stray_en", 32'({wfifo_rd_en, rfifo_wr_en}), 0);
        tick;
        rd_ack = 1'b0; sdram_wr_ack = 1'b0; flush = 1'b0;
        check_eq("req_hold", 32'(is_wr ? wr_req : rd_req), 32'(k == 0));
        check_eq("other_req", 32'(is_wr ? rd_req : wr_req), 0);
      end
      if (is_wr) sdram_wr_ack = 1'b1;
      else rd_ack = 1'b1;
      #1;
      check_eq("ack_en", 32'(is_wr ? wfifo_rd_en : rfifo_wr_en), 1);
      tick;
      sdram_wr_ack = 1'b0; rd_ack = 1'b0;
      check_eq("req_drop", 32'(wr_req | rd_req), 0);
      check_eq("busy_burst", 32'(busy), 1);
    end
    tick;
    if (is_wr) begin
      m_fill += BL; m_wptr = next_ptr(m_wptr); m_wbursts++;
    end else begin
      m_fill -= BL; m_rptr = next_ptr(m_rptr); m_rbursts++;
    end
    check_eq("done_fill", 32'(fill_words), m_fill);
    check_eq("done_wr_addr", 32'(wr_addr), m_wptr);
    check_eq("done_rd_addr", 32'(rd_addr), m_rptr);
    check_eq("done_busy", 32'(busy), 0);
    check_eq("ack_err", 32'(ack_err), 32'(m_err));
  endtask

  // One IDLE decision with random inputs; the model predicts the grant (or flush).
  task automatic idle_step;
    bit gw, gr, wr_ok, rd_ok;
    wfifo_level = 10'($urandom_range(0, 16));
    rfifo_free  = 10'($urandom_range(0, 16));
    rd_enable   = ($urandom_range(0, 3) != 0);
    flush       = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 0) rd_ack = 1'b1;
      else sdram_wr_ack = 1'b1;
      m_err = 1'b1;
    end
    #1;
    check_eq("idle_en", 32'({wfifo_rd_en, rfifo_wr_en}), 0);
    if (flush || m_pend) begin
      m_fill = 0; m_wptr = AMIN; m_rptr = AMIN; m_pend = 1'b0;
      gw = 1'b0; gr = 1'b0;
    end else begin
      wr_ok = (int'(wfifo_level) >= BL) && (CAP - m_fill >= BL);
      rd_ok = rd_enable && (m_fill >= BL) && (int'(rfifo_free) >= BL);
      if (wr_ok && rd_ok) begin
        gw = m_last_rd; gr = !m_last_rd;
      end else begin
        gw = wr_ok; gr = rd_ok;
      end
    end
    tick;
    flush = 1'b0; rd_ack = 1'b0; sdram_wr_ack = 1'b0;
    check_eq("grant_wr", 32'(wr_req), 32'(gw));
    check_eq("grant_rd", 32'(rd_req), 32'(gr));
    check_eq("idle_fill", 32'(fill_words), m_fill);
    if (gw) check_eq("grant_wr_addr", 32'(wr_addr), m_wptr);
    if (gr) check_eq("grant_rd_addr", 32'(rd_addr), m_rptr);
    if (gw || gr) begin
      m_last_rd = gr;
      run_burst(gw);
    end
  endtask

  initial begin
    rst = 1'b1; init_end = 1'b0; rd_enable = 1'b0; flush = 1'b0;
    sdram_wr_ack = 1'b0; rd_ack = 1'b0; wfifo_level = '0; rfifo_free = '0;
    tick;
    tick;
    check_reset_vals("reset");
    check_eq("wr_burst_len", 32'(wr_burst_len), BL);
    check_eq("rd_burst_len", 32'(rd_burst_len), BL);

    rst = 1'b0; wfifo_level = 10'd20;
    for (int i = 0; i < 50; i++) begin
      tick;
      check_eq("no_req_before_init", 32'(wr_req | rd_req | busy), 0);
    end
    init_end = 1'b1;
    tick;
    tick;
    check_eq("init_wr_req", 32'(wr_req), 1);
    check_eq("init_wr_addr", 32'(wr_addr), AMIN);
    m_last_rd = 1'b0;
    run_burst(1'b1);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) init_end = 1'b0;
      idle_step();
    end

    check_eq("wfifo_pops", pops, m_wbursts * BL);
    check_eq("rfifo_pushes", pushes, m_rbursts * BL);

    // Reset in the middle of a write burst
    flush = 1'b1; wfifo_level = '0; rd_enable = 1'b0;
    tick;
    flush = 1'b0; wfifo_level = 10'd20;
    check_eq("flush_fill", 32'(fill_words), 0);
    tick;
    check_eq("mid_wr_req", 32'(wr_req), 1);
    sdram_wr_ack = 1'b1;
    repeat (3) tick;
    sdram_wr_ack = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0; wfifo_level = '0;
    check_reset_vals("mid_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
